// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants and the fetch FSM state type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO buffering fetched {pc, instr} words
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage owning the PC, imem req/ack fetch, buffering and redirect
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_ce,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_branch_pc,
  output logic        o_misalign
);
  import riscv_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state;
  logic [31:0] pc;
  logic [63:0] fifo_dout;
  logic fifo_full, fifo_empty, push, pop, room;
  logic [CW-1:0] count;
  logic [CW:0] count_next;
  assign push       = state == REQ && i_imem_ack && !i_flush && !fifo_full;
  assign pop        = !i_stall && !fifo_empty && !i_flush;
  assign count_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign room       = count_next < (CW+1)'(FIFO_DEPTH);
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .clear(i_flush),
    .din({pc, i_imem_rdata}),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      o_imem_req  <= 1'b0;
      o_imem_addr <= RESET_PC;
      o_instr     <= NOP_INSTR;
      o_pc        <= '0;
      o_ce        <= 1'b0;
      o_misalign  <= 1'b0;
    end else begin
      o_misalign <= i_flush && (|i_branch_pc[1:0]);
      if (i_flush) begin
        pc         <= {i_branch_pc[31:2], 2'b00};
        o_imem_req <= 1'b0;
        state      <= (state != IDLE && !i_imem_ack) ? DISCARD : IDLE;
        o_ce       <= 1'b0;
        o_instr    <= NOP_INSTR;
      end else begin
        if (!i_stall) begin
          o_ce    <= pop;
          o_instr <= pop ? fifo_dout[31:0] : NOP_INSTR;
          if (pop) o_pc <= fifo_dout[63:32];
        end
        case (state)
          IDLE: if (room) begin
            o_imem_req  <= 1'b1;
            o_imem_addr <= pc;
            state       <= REQ;
          end
          REQ: if (i_imem_ack) begin
            pc <= pc + 32'd4;
            if (room) o_imem_addr <= pc + 32'd4;
            else begin
              o_imem_req <= 1'b0;
              state      <= IDLE;
            end
          end
          default: if (i_imem_ack) state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch
module tb_instr_fetch;
  logic clk = 0, rst = 1;
  logic o_imem_req, o_ce, o_misalign;
  logic [31:0] o_imem_addr, o_instr, o_pc;
  logic i_imem_ack = 0, i_stall = 0, i_flush = 0;
  logic [31:0] i_imem_rdata = '0, i_branch_pc = '0;
  int n_chk = 0, n_fail = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K = 32'hA5A5_0000;
  instr_fetch dut (
    .clk(clk),
    .rst(rst),
    .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack),
    .i_imem_rdata(i_imem_rdata),
    .o_instr(o_instr),
    .o_pc(o_pc),
    .o_ce(o_ce),
    .i_stall(i_stall),
    .i_flush(i_flush),
    .i_branch_pc(i_branch_pc),
    .o_misalign(o_misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic ack);
    i_imem_ack = ack;
    i_imem_rdata = o_imem_addr ^ K;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_req", o_imem_req, 0);
    chk("rst_addr", o_imem_addr, 0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc", o_pc, 0);
    chk("rst_ce", o_ce, 0);
    chk("rst_mis", o_misalign, 0);
    step(o_imem_req);
    chk("c1_req", o_imem_req, 1);
    chk("c1_addr", o_imem_addr, 0);
    step(o_imem_req);
    chk("c2_ce", o_ce, 0);
    chk("c2_addr", o_imem_addr, 4);
    step(o_imem_req);
    chk("c3_ce", o_ce, 1);
    chk("c3_pc", o_pc, 0);
    chk("c3_instr", o_instr, K);
    for (int k = 1; k <= 4; k++) begin
      step(o_imem_req);
      chk("stream_ce", o_ce, 1);
      chk("stream_pc", o_pc, 32'(4 * k));
      chk("stream_instr", o_instr, 32'(4 * k) ^ K);
    end
    i_stall = 1;
    for (int k = 0; k < 5; k++) begin
      step(o_imem_req);
      chk("stall_pc", o_pc, 16);
      chk("stall_ce", o_ce, 1);
      chk("stall_req", o_imem_req, 0);
    end
    i_stall = 0;
    step(o_imem_req);
    chk("rel_req", o_imem_req, 1);
    chk("rel_addr", o_imem_addr, 28);
    chk("rel_pc20", o_pc, 20);
    step(o_imem_req);
    chk("rel_pc24", o_pc, 24);
    step(o_imem_req);
    chk("rel_pc28", o_pc, 28);
    chk("lat_addr0", o_imem_addr, 36);
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("lat_addr", o_imem_addr, 32'(36 + 4 * i));
      chk("lat_pc", o_pc, 32'(32 + 4 * i));
      chk("lat_ce1", o_ce, 1);
      step(0);
      chk("lat_ce0", o_ce, 0);
      chk("lat_req", o_imem_req, 1);
      chk("lat_addr2", o_imem_addr, 32'(36 + 4 * i));
      step(0);
      chk("lat_addr3", o_imem_addr, 32'(36 + 4 * i));
      step(1);
      chk("lat_next", o_imem_addr, 32'(40 + 4 * i));
    end
    i_flush = 1;
    i_branch_pc = 32'h100;
    step(0);
    i_flush = 0;
    chk("fl_ce", o_ce, 0);
    chk("fl_instr", o_instr, NOP);
    chk("fl_req", o_imem_req, 0);
    chk("fl_mis", o_misalign, 0);
    step(0);
    chk("fl_req2", o_imem_req, 0);
    step(1);
    chk("fl_req3", o_imem_req, 0);
    chk("fl_ce3", o_ce, 0);
    step(0);
    chk("fl_req4", o_imem_req, 1);
    chk("fl_addr4", o_imem_addr, 32'h100);
    step(o_imem_req);
    chk("fl_ce5", o_ce, 0);
    step(o_imem_req);
    chk("fl_ce6", o_ce, 1);
    chk("fl_pc6", o_pc, 32'h100);
    chk("fl_instr6", o_instr, 32'h100 ^ K);
    i_flush = 1;
    i_stall = 1;
    i_branch_pc = 32'h203;
    step(1);
    i_flush = 0;
    i_stall = 0;
    chk("fsa_mis", o_misalign, 1);
    chk("fsa_ce", o_ce, 0);
    chk("fsa_instr", o_instr, NOP);
    chk("fsa_req", o_imem_req, 0);
    step(o_imem_req);
    chk("fsa_mis2", o_misalign, 0);
    chk("fsa_req2", o_imem_req, 1);
    chk("fsa_addr2", o_imem_addr, 32'h200);
    step(o_imem_req);
    chk("fsa_ce3", o_ce, 0);
    step(o_imem_req);
    chk("fsa_ce4", o_ce, 1);
    chk("fsa_pc4", o_pc, 32'h200);
    chk("fsa_instr4", o_instr, 32'h200 ^ K);
    chk("pre_rst_addr", o_imem_addr, 32'h208);
    rst = 1;
    step(0);
    rst = 0;
    chk("mr_req", o_imem_req, 0);
    chk("mr_addr", o_imem_addr, 0);
    chk("mr_ce", o_ce, 0);
    chk("mr_pc", o_pc, 0);
    step(1);
    chk("mr_req1", o_imem_req, 1);
    chk("mr_addr1", o_imem_addr, 0);
    chk("mr_ce1", o_ce, 0);
    step(o_imem_req);
    chk("mr_ce2", o_ce, 0);
    step(o_imem_req);
    chk("mr_ce3", o_ce, 1);
    chk("mr_pc3", o_pc, 0);
    chk("mr_instr3", o_instr, K);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
